timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer_pkg.sv | 35 +++
 rtl/timer.sv | 94 +++++++++
 tb/tb_timer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer: register map, CTRL layout,
// mode encodings and FSM state encoding.
package timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned CTRL_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_MODE_MSB = 2;
  localparam int unsigned CTRL_IM_BIT   = 3;

  // Field order matches the bit positions above (MSB first).
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt. Register file and FSM share one clocked process.
module timer
  import timer_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] rd_o,
  output logic              irq_o
);

  state_t            state_q;
  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] preset_q;
  logic [DATA_W-1:0] count_q;
  logic              irq_pending_q;

  logic ctrl_wr;
  logic preset_wr;

  assign ctrl_wr   = we_i && (addr_i == ADDR_CTRL);
  assign preset_wr = we_i && (addr_i == ADDR_PRESET);

  // CPU writes are applied after the FSM so they win over same-cycle FSM updates.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '0;
      preset_q      <= '0;
      count_q       <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_q.en) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!ctrl_q.en) begin
            state_q <= ST_IDLE;
          end else begin
            count_q <= preset_q;
            state_q <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!ctrl_q.en) begin
            state_q <= ST_IDLE;
          end else if (count_q > DATA_W'(1)) begin
            count_q <= count_q - DATA_W'(1);
          end else begin
            // Covers PRESET=0 as well: never wraps below zero.
            count_q       <= '0;
            irq_pending_q <= 1'b1;
            state_q       <= ST_INT;
          end
        end
        ST_INT: begin
          if (ctrl_q.mode == MODE_RELOAD) begin
            irq_pending_q <= 1'b0;
          end else begin
            ctrl_q.en <= 1'b0;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (ctrl_wr) begin
        ctrl_q        <= ctrl_t'(wd_i[CTRL_W-1:0]);
        irq_pending_q <= 1'b0;
      end
      if (preset_wr) begin
        preset_q <= wd_i;
      end
    end
  end

  // Read mux; address 3 reads zero.
  always_comb begin
    rd_o = '0;
    case (addr_i)
      ADDR_CTRL:   rd_o = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: rd_o = preset_q;
      ADDR_COUNT:  rd_o = count_q;
      default:     rd_o = '0;
    endcase
  end

  assign irq_o = ctrl_q.im & irq_pending_q;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: table-driven per-cycle vectors plus
// hand-written sequences for reset, masking and mid-count corner cases.
module tb_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer dut (
    .clk_i  (clk),
    .reset_i(rst),
    .addr_i (addr),
    .we_i   (we),
    .wd_i   (wd),
    .rd_o   (rd),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  // One vector = one clock cycle; expectations are for the state before the edge.
  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    cycle();
    we   = 1'b0;
    wd   = '0;
  endtask

  task automatic read(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rd, exp);
  endtask

  task automatic check_irq(input string name, input logic exp);
    check(name, 32'(irq), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    we  = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  function automatic void add(input logic w, input logic [1:0] a, input logic [31:0] d,
                              input logic [31:0] r, input logic i);
    vec_t v;
    v.we      = w;
    v.addr    = a;
    v.wd      = d;
    v.exp_rd  = r;
    v.exp_irq = i;
    vq.push_back(v);
  endfunction

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      we   = vq[i].we;
      addr = vq[i].addr;
      wd   = vq[i].wd;
      #1;
      check($sformatf("%s[%0d].rd", tag, i), rd, vq[i].exp_rd);
      check($sformatf("%s[%0d].irq", tag, i), 32'(irq), 32'(vq[i].exp_irq));
      cycle();
    end
    we = 1'b0;
    wd = '0;
    vq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst  = 1'b1;
    we   = 1'b0;
    addr = 2'd0;
    wd   = '0;
    cycle();
    rst = 1'b0;

    // Reset state
    for (int a = 0; a < 4; a++) read($sformatf("reset.rd%0d", a), 2'(a), 32'h0);
    check_irq("reset.irq", 1'b0);

    // Start a count, then reset with a simultaneous write: reset must win
    write(2'd1, 32'hDEAD_BEEF);
    write(2'd0, 32'h9);
    cycle();
    cycle();
    read("preload.count", 2'd2, 32'hDEAD_BEEF);
    rst  = 1'b1;
    we   = 1'b1;
    addr = 2'd1;
    wd   = 32'h55;
    cycle();
    rst = 1'b0;
    we  = 1'b0;
    for (int a = 0; a < 4; a++) read($sformatf("rst_ovr.rd%0d", a), 2'(a), 32'h0);
    check_irq("rst_ovr.irq", 1'b0);

    // One-shot, PRESET=5: COUNT 5..0, IRQ held, Enable self-clears, CTRL write drops IRQ
    do_reset();
    add(1, 2'd1, 32'd5, 32'd0, 0);
    add(1, 2'd0, 32'h9, 32'd0, 0);
    add(0, 2'd2, 0, 32'd0, 0);
    add(0, 2'd2, 0, 32'd0, 0);
    for (int c = 5; c >= 1; c--) add(0, 2'd2, 0, 32'(c), 0);
    add(0, 2'd2, 0, 32'd0, 1);
    add(0, 2'd0, 0, 32'h8, 1);
    add(0, 2'd0, 0, 32'h8, 1);
    add(1, 2'd0, 32'h8, 32'h8, 1);
    add(0, 2'd0, 0, 32'h8, 0);
    add(0, 2'd2, 0, 32'd0, 0);
    run_vecs("oneshot");

    // Auto-reload PRESET=1: period 4, one-cycle pulse; then disable with 0xA
    do_reset();
    add(1, 2'd1, 32'd1, 32'd0, 0);
    add(1, 2'd0, 32'hB, 32'd0, 0);
    for (int k = 0; k < 3; k++) begin
      add(0, 2'd2, 0, 32'd0, 0);
      add(0, 2'd2, 0, 32'd0, 0);
      add(0, 2'd2, 0, 32'd1, 0);
      add(0, 2'd2, 0, 32'd0, 1);
    end
    add(1, 2'd0, 32'hA, 32'hB, 0);
    for (int k = 0; k < 8; k++) add(0, 2'd0, 0, 32'hA, 0);
    run_vecs("reload");

    // PRESET=0 behaves as PRESET=1
    do_reset();
    add(1, 2'd1, 32'd0, 32'd0, 0);
    add(1, 2'd0, 32'hB, 32'd0, 0);
    for (int k = 0; k < 2; k++) begin
      add(0, 2'd2, 0, 32'd0, 0);
      add(0, 2'd2, 0, 32'd0, 0);
      add(0, 2'd2, 0, 32'd0, 0);
      add(0, 2'd2, 0, 32'd0, 1);
    end
    run_vecs("preset0");

    // CTRL write in INT beats the FSM's Enable clear
    do_reset();
    add(1, 2'd1, 32'd1, 32'd0, 0);
    add(1, 2'd0, 32'h9, 32'd0, 0);
    add(0, 2'd2, 0, 32'd0, 0);
    add(0, 2'd2, 0, 32'd0, 0);
    add(0, 2'd2, 0, 32'd1, 0);
    add(1, 2'd0, 32'h9, 32'h9, 1);
    add(0, 2'd0, 0, 32'h9, 0);
    add(0, 2'd2, 0, 32'd0, 0);
    add(0, 2'd2, 0, 32'd1, 0);
    add(0, 2'd0, 0, 32'h9, 1);
    add(0, 2'd0, 0, 32'h8, 1);
    run_vecs("prio");

    // Masked completion: IRQ never rises, and the CTRL write clears pending
    do_reset();
    write(2'd1, 32'd2);
    write(2'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check_irq($sformatf("mask.irq%0d", k), 1'b0);
    end
    read("mask.ctrl", 2'd0, 32'h0);
    read("mask.count", 2'd2, 32'h0);
    write(2'd0, 32'h8);
    check_irq("mask.after_wr", 1'b0);
    read("mask.ctrl8", 2'd0, 32'h8);

    // Mid-count register writes
    do_reset();
    write(2'd1, 32'd10);
    write(2'd0, 32'h9);
    cycle();
    cycle();
    read("mid.load", 2'd2, 32'd10);
    cycle();
    write(2'd1, 32'd100);
    read("mid.preset_wr", 2'd2, 32'd8);
    write(2'd2, 32'hFFFF);
    read("mid.count_wr", 2'd2, 32'd7);
    write(2'd3, 32'h1234);
    read("mid.count_wr3", 2'd2, 32'd6);
    read("mid.addr3", 2'd3, 32'h0);
    read("mid.preset", 2'd1, 32'd100);
    n = 0;
    while (!irq && n < 20) begin
      cycle();
      n++;
    end
    check("mid.irq_latency", 32'(n), 32'd6);
    check_irq("mid.irq", 1'b1);

    // New PRESET used at the next LOAD
    write(2'd0, 32'h9);
    check_irq("mid.rearm_irq", 1'b0);
    cycle();
    cycle();
    read("mid.new_preset", 2'd2, 32'd100);

    // Disable during CNT: COUNT freezes, no IRQ
    write(2'd0, 32'h8);
    read("dis.count0", 2'd2, 32'd99);
    cycle();
    read("dis.count1", 2'd2, 32'd99);
    cycle();
    read("dis.count2", 2'd2, 32'd99);
    check_irq("dis.irq", 1'b0);
    read("dis.ctrl", 2'd0, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
